// File: rtl/ysyx_22041752_axi_bridge_pkg.sv
// Shared widths, FSM encoding and request-source tag for the SRAM-to-AXI4-lite bridge.
package ysyx_22041752_axi_bridge_pkg;

  localparam int AXI_ADDR_WD = 64;
  localparam int AXI_DATA_WD = 64;
  localparam int AXI_WEN_WD  = AXI_DATA_WD / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

endpackage

// File: rtl/ysyx_22041752_axi_bridge.sv
// Arbitrates the core's inst/data SRAM ports onto a single AXI4-lite master,
// one transaction at a time, data port winning ties.
module ysyx_22041752_axi_bridge
  import ysyx_22041752_axi_bridge_pkg::*;
#(
  parameter int ADDR_WD = AXI_ADDR_WD,
  parameter int DATA_WD = AXI_DATA_WD,
  parameter int WEN_WD  = AXI_WEN_WD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_req,
  input  logic [ADDR_WD-1:0] inst_addr,
  output logic [DATA_WD-1:0] inst_rdata,
  output logic               inst_ok,
  input  logic               data_req,
  input  logic [WEN_WD-1:0]  data_wen,
  input  logic [ADDR_WD-1:0] data_addr,
  input  logic [DATA_WD-1:0] data_wdata,
  output logic [DATA_WD-1:0] data_rdata,
  output logic               data_ok,
  output logic [ADDR_WD-1:0] araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DATA_WD-1:0] rdata,
  input  logic               rvalid,
  output logic               rready,
  output logic [ADDR_WD-1:0] awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_WD-1:0] wdata,
  output logic [WEN_WD-1:0]  wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready
);

  logic [2:0]         state_q, state_d;
  src_e               src_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [DATA_WD-1:0] wdata_q;
  logic [WEN_WD-1:0]  wen_q;
  logic [DATA_WD-1:0] inst_rdata_q;
  logic [DATA_WD-1:0] data_rdata_q;
  logic               aw_done_q;
  logic               w_done_q;

  logic aw_fire, w_fire, aw_all, w_all;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  // AW and W retire independently; a channel counts as done if it fired now or earlier
  assign aw_all  = aw_done_q | aw_fire;
  assign w_all   = w_done_q | w_fire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_req)      state_d = (data_wen != '0) ? ST_WR : ST_AR;
        else if (inst_req) state_d = ST_AR;
      end
      ST_AR:   if (arready)         state_d = ST_R;
      ST_R:    if (rvalid)          state_d = ST_DONE;
      ST_WR:   if (aw_all && w_all) state_d = ST_B;
      ST_B:    if (bvalid)          state_d = ST_DONE;
      ST_DONE:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_INST;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (data_req) begin
            src_q   <= SRC_DATA;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            wen_q   <= data_wen;
          end else if (inst_req) begin
            src_q   <= SRC_INST;
            addr_q  <= inst_addr;
            wdata_q <= '0;
            wen_q   <= '0;
          end
        end
        ST_R: begin
          if (rvalid) begin
            if (src_q == SRC_DATA) data_rdata_q <= rdata;
            else                   inst_rdata_q <= rdata;
          end
        end
        ST_WR: begin
          if (aw_fire) aw_done_q <= 1'b1;
          if (w_fire)  w_done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign araddr  = addr_q;
  assign arvalid = (state_q == ST_AR);
  assign rready  = (state_q == ST_R);
  assign awaddr  = addr_q;
  assign awvalid = (state_q == ST_WR) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wvalid  = (state_q == ST_WR) && !w_done_q;
  assign bready  = (state_q == ST_B);

  assign inst_ok    = (state_q == ST_DONE) && (src_q == SRC_INST);
  assign data_ok    = (state_q == ST_DONE) && (src_q == SRC_DATA);
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_ysyx_22041752_axi_bridge.sv
// Directed + randomized bench: behavioural AXI slave with programmable wait states and
// a flat reference memory that predicts read data and request-to-ok latency.
module tb_ysyx_22041752_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic [63:0] inst_addr, data_addr, data_wdata;
  logic [7:0]  data_wen;
  logic [63:0] inst_rdata, data_rdata;
  logic        inst_ok, data_ok;
  logic [63:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_22041752_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference memory ----------------
  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] slv_mem [logic [63:0]];

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] slv_read(input logic [63:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  // ---------------- AXI slave ----------------
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int b_hs = 0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, aw_got, w_got, b_pend;
    bit p_ar, p_r, p_aw, p_w, p_b;
    logic [63:0] p_araddr, p_awaddr, p_wdata, r_addr, s_awaddr, s_wdata;
    logic [7:0]  p_wstrb, s_wstrb;
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
    {r_pend, aw_got, w_got, b_pend, p_ar, p_r, p_aw, p_w, p_b} = '0;
    {p_araddr, p_awaddr, p_wdata, r_addr, s_awaddr, s_wdata} = '0;
    {p_wstrb, s_wstrb} = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
        {r_pend, aw_got, w_got, b_pend, p_ar, p_r, p_aw, p_w, p_b} = '0;
      end else begin
        // retire handshakes that happened on the last rising edge
        if (p_ar) begin r_pend = 1; r_cnt = 0; r_addr = p_araddr; ar_cnt = 0; end
        if (p_r)  r_pend = 0;
        if (p_aw) begin aw_got = 1; s_awaddr = p_awaddr; aw_cnt = 0; end
        if (p_w)  begin w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_cnt = 0; end
        if (p_b)  begin b_pend = 0; b_hs++; end
        if (aw_got && w_got) begin
          slv_mem[s_awaddr] = merge(slv_read(s_awaddr), s_wdata, s_wstrb);
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        arready = 0;
        if (arvalid && !r_pend) begin
          if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
        end
        rvalid = 0;
        if (r_pend) begin
          if (r_cnt >= r_dly) begin rvalid = 1; rdata = slv_read(r_addr); end else r_cnt++;
        end
        awready = 0;
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
        end
        wready = 0;
        if (wvalid && !w_got) begin
          if (w_cnt >= w_dly) wready = 1; else w_cnt++;
        end
        bvalid = 0;
        if (b_pend) begin
          if (b_cnt >= b_dly) bvalid = 1; else b_cnt++;
        end
        p_ar = arvalid && arready; p_araddr = araddr;
        p_r  = rvalid && rready;
        p_aw = awvalid && awready; p_awaddr = awaddr;
        p_w  = wvalid && wready;   p_wdata = wdata; p_wstrb = wstrb;
        p_b  = bvalid && bready;
      end
    end
  end

  // ---------------- one request on one port ----------------
  int aw_drop, w_drop;

  task automatic txn(input bit is_data, input logic [7:0] wen, input logic [63:0] addr,
                     input logic [63:0] wd, input int d_ar, input int d_r, input int d_aw,
                     input int d_w, input int d_b);
    bit          is_wr, seen, pav, par, paw, pawr, pw, pwr;
    int          lat, vcyc, exp_lat, b0;
    logic [63:0] exp_rd, own_before, other_before, pa, pwa, pwd;
    ar_dly = d_ar; r_dly = d_r; aw_dly = d_aw; w_dly = d_w; b_dly = d_b;
    is_wr = is_data && (wen != 8'h00);
    exp_rd = '0;
    if (is_wr) begin
      exp_lat = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
      ref_mem[addr] = merge(ref_read(addr), wd, wen);
    end else begin
      exp_lat = 3 + d_ar + d_r;
      exp_rd  = ref_read(addr);
    end
    own_before   = is_data ? data_rdata : inst_rdata;
    other_before = is_data ? inst_rdata : data_rdata;
    b0 = b_hs;
    @(negedge clk);
    if (is_data) begin
      data_req = 1; data_wen = wen; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1; inst_addr = addr;
    end
    {seen, pav, par, paw, pawr, pw, pwr} = '0;
    {pa, pwa, pwd} = '0;
    lat = 0; vcyc = 0; aw_drop = 0; w_drop = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (vcyc == 0 && (arvalid || awvalid)) begin
        vcyc = lat;
        if (is_wr) begin
          chk("awaddr", awaddr, addr);
          chk("wdata", wdata, wd);
          chk("wstrb", 64'(wstrb), 64'(wen));
          chk("wvalid_rise", 64'(wvalid), 64'd1);
        end else begin
          chk("araddr", araddr, addr);
        end
      end
      if (pav && !par) begin
        chk("arvalid_hold", 64'(arvalid), 64'd1);
        chk("araddr_hold", araddr, pa);
      end
      if (paw && !pawr) begin
        chk("awvalid_hold", 64'(awvalid), 64'd1);
        chk("awaddr_hold", awaddr, pwa);
      end
      if (pw && !pwr) begin
        chk("wvalid_hold", 64'(wvalid), 64'd1);
        chk("wdata_hold", wdata, pwd);
      end
      if (paw && !awvalid && aw_drop == 0) aw_drop = lat;
      if (pw && !wvalid && w_drop == 0)    w_drop = lat;
      if (is_data ? inst_ok : data_ok) chk("wrong_port_ok", 64'd1, 64'd0);
      seen = is_data ? data_ok : inst_ok;
      pav = arvalid; par = arready; pa = araddr;
      paw = awvalid; pawr = awready; pwa = awaddr;
      pw = wvalid; pwr = wready; pwd = wdata;
    end
    chk("ok_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("valid_cycle", 64'(vcyc), 64'd1);
    chk("rdata", is_data ? data_rdata : inst_rdata, is_wr ? own_before : exp_rd);
    chk("other_rdata", is_data ? inst_rdata : data_rdata, other_before);
    if (is_data) data_req = 0; else inst_req = 0;
    @(negedge clk);
    chk("ok_one_cycle", 64'({inst_ok, data_ok}), 64'd0);
    chk("rdata_hold", is_data ? data_rdata : inst_rdata, is_wr ? own_before : exp_rd);
    if (is_wr) chk("b_count", 64'(b_hs - b0), 64'd1);
  endtask

  initial begin
    int          n, d_cyc, i_cyc, d_cnt, i_cnt;
    logic [63:0] e_d, e_i, a;
    logic [7:0]  w;
    reset = 1; inst_req = 0; data_req = 0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_wen = '0;
    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, inst_ok, data_ok}), 64'd0);
    chk("rst_inst_rdata", inst_rdata, 64'd0);
    chk("rst_data_rdata", data_rdata, 64'd0);
    reset = 0;

    // zero-wait fetch
    txn(0, 8'h00, 64'h8000_0000, '0, 0, 0, 0, 0, 0);

    // simultaneous requests: data read first, then fetch
    ar_dly = 0; r_dly = 0;
    e_d = ref_read(64'h8000_0040);
    e_i = ref_read(64'h8000_0080);
    @(negedge clk);
    data_req = 1; data_wen = 0; data_addr = 64'h8000_0040;
    inst_req = 1; inst_addr = 64'h8000_0080;
    d_cnt = 0; i_cnt = 0; d_cyc = 0; i_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (data_ok) begin d_cnt++; d_cyc = c; data_req = 0; end
      if (inst_ok) begin i_cnt++; i_cyc = c; inst_req = 0; end
    end
    chk("both_data_ok_cnt", 64'(d_cnt), 64'd1);
    chk("both_inst_ok_cnt", 64'(i_cnt), 64'd1);
    chk("both_data_cycle", 64'(d_cyc), 64'd3);
    chk("both_inst_cycle", 64'(i_cyc), 64'd7);
    chk("both_data_rdata", data_rdata, e_d);
    chk("both_inst_rdata", inst_rdata, e_i);
    inst_req = 0; data_req = 0;

    // partial store, AW late by three cycles, W immediate
    txn(1, 8'h0F, 64'h8000_1000, 64'h1122_3344_5566_7788, 0, 0, 3, 0, 0);
    chk("w_drop_cycle", 64'(w_drop), 64'd2);
    chk("aw_drop_cycle", 64'(aw_drop), 64'd5);
    txn(1, 8'h00, 64'h8000_1000, '0, 0, 0, 0, 0, 0);

    // AR stalled for ten cycles
    txn(0, 8'h00, 64'h8000_2000, '0, 10, 0, 0, 0, 0);

    // reset while waiting for R
    ar_dly = 0; r_dly = 5;
    @(negedge clk);
    inst_req = 1; inst_addr = 64'h8000_3000;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    chk("reached_r", 64'(rready), 64'd1);
    reset = 1; inst_req = 0;
    @(negedge clk);
    chk("midrst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, inst_ok, data_ok}), 64'd0);
    chk("midrst_inst_rdata", inst_rdata, 64'd0);
    chk("midrst_data_rdata", data_rdata, 64'd0);
    reset = 0;
    txn(0, 8'h00, 64'h8000_3000, '0, 0, 0, 0, 0, 0);

    // randomized mix over a small address window
    for (int k = 0; k < 24; k++) begin
      a = 64'h8000_4000 + 64'(8 * $urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 9) < 6)
        txn(1, w, a, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        txn(0, 8'h00, a, '0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
